// File: rtl/psola_pkg.sv
// Shared types and defaults for the PSOLA window pipeline.
// Holds the scheduler state encoding and the default window and tau settings.
package psola_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      DETECT  = 2'd1,
      SYNTH   = 2'd2,
      PUBLISH = 2'd3
   } sched_state_e;

   localparam int DEFAULT_WINDOW_SIZE = 2048;
   localparam int DEFAULT_MIN_TAU     = 20;
   localparam int DEFAULT_TAU_WIDTH   = 11;

endpackage

// File: rtl/window_bank_counter.sv
// Counts samples into the fill bank and swaps banks at each window boundary.
// boundary_out is a same-cycle strobe; window_done_out is its registered pulse.
module window_bank_counter
   import psola_pkg::*;
#(
   parameter int WINDOW_SIZE = DEFAULT_WINDOW_SIZE
) (
   input  logic                           clk_in,
   input  logic                           rst_in,
   input  logic                           sample_valid_in,
   output logic [$clog2(WINDOW_SIZE)-1:0] write_addr_out,
   output logic                           write_bank_out,
   output logic                           window_done_out,
   output logic                           boundary_out
);

   localparam int AW = $clog2(WINDOW_SIZE);
   localparam logic [AW-1:0] LAST_ADDR = AW'(WINDOW_SIZE - 1);

   assign boundary_out = sample_valid_in && (write_addr_out == LAST_ADDR);

   // WINDOW_SIZE is a power of two, so the address wraps to 0 on its own.
   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         write_addr_out  <= '0;
         write_bank_out  <= 1'b0;
         window_done_out <= 1'b0;
      end else begin
         window_done_out <= boundary_out;
         if (sample_valid_in) begin
            write_addr_out <= write_addr_out + AW'(1);
         end
         if (boundary_out) begin
            write_bank_out <= ~write_bank_out;
         end
      end
   end

endmodule

// File: rtl/psola_window_scheduler.sv
// Sequences detect -> PSOLA -> publish for each completed window; owns bank selection.
// All outputs registered; pulses appear the cycle after their trigger.
module psola_window_scheduler
   import psola_pkg::*;
#(
   parameter int WINDOW_SIZE = DEFAULT_WINDOW_SIZE,
   parameter int TAU_WIDTH   = DEFAULT_TAU_WIDTH,
   parameter int MIN_TAU     = DEFAULT_MIN_TAU
) (
   input  logic                           clk_in,
   input  logic                           rst_in,
   input  logic                           sample_valid_in,
   output logic [$clog2(WINDOW_SIZE)-1:0] write_addr_out,
   output logic                           write_bank_out,
   output logic                           read_bank_out,
   output logic                           window_done_out,
   output logic                           detect_start_out,
   input  logic [TAU_WIDTH-1:0]           tau_in,
   input  logic                           tau_valid_in,
   output logic                           psola_start_out,
   output logic [TAU_WIDTH-1:0]           psola_tau_out,
   input  logic                           psola_done_in,
   output logic                           abort_out,
   output logic                           out_bank_out,
   output logic                           bypass_out,
   output logic [7:0]                     overrun_count_out,
   output logic                           busy_out
);

   localparam logic [31:0] MIN_TAU_U = MIN_TAU;
   localparam logic [31:0] MAX_TAU_U = WINDOW_SIZE / 2;

   sched_state_e         state_q, state_d;
   logic                 bypass_flag_q, bypass_flag_d;
   logic                 boundary;
   logic                 tau_unvoiced;
   logic [31:0]          tau_ext;
   logic [7:0]           count_sat;
   logic                 detect_start_d, psola_start_d, abort_d;
   logic                 out_bank_d, bypass_d;
   logic [TAU_WIDTH-1:0] tau_d;
   logic [7:0]           count_d;

   window_bank_counter #(
      .WINDOW_SIZE(WINDOW_SIZE)
   ) u_counter (
      .clk_in          (clk_in),
      .rst_in          (rst_in),
      .sample_valid_in (sample_valid_in),
      .write_addr_out  (write_addr_out),
      .write_bank_out  (write_bank_out),
      .window_done_out (window_done_out),
      .boundary_out    (boundary)
   );

   assign read_bank_out = ~write_bank_out;
   assign busy_out      = (state_q != IDLE);
   assign tau_ext       = 32'(tau_in);
   assign tau_unvoiced  = (tau_ext < MIN_TAU_U) || (tau_ext > MAX_TAU_U);
   assign count_sat     = (overrun_count_out == 8'hFF) ? 8'hFF : overrun_count_out + 8'd1;

   always_comb begin
      state_d        = state_q;
      bypass_flag_d  = bypass_flag_q;
      detect_start_d = 1'b0;
      psola_start_d  = 1'b0;
      abort_d        = 1'b0;
      tau_d          = psola_tau_out;
      out_bank_d     = out_bank_out;
      bypass_d       = bypass_out;
      count_d        = overrun_count_out;

      case (state_q)
         IDLE: begin
            if (boundary) begin
               detect_start_d = 1'b1;
               state_d        = DETECT;
            end
         end
         DETECT: begin
            // A boundary outranks a same-cycle tau: the tau belongs to a window being dropped.
            if (boundary) begin
               abort_d        = 1'b1;
               count_d        = count_sat;
               detect_start_d = 1'b1;
               state_d        = DETECT;
            end else if (tau_valid_in) begin
               if (tau_unvoiced) begin
                  bypass_flag_d = 1'b1;
                  state_d       = PUBLISH;
               end else begin
                  tau_d         = tau_in;
                  psola_start_d = 1'b1;
                  bypass_flag_d = 1'b0;
                  state_d       = SYNTH;
               end
            end
         end
         SYNTH: begin
            if (psola_done_in && boundary) begin
               // Finished just in time: publish the old read bank now and start the next window.
               out_bank_d     = read_bank_out;
               bypass_d       = bypass_flag_q;
               detect_start_d = 1'b1;
               state_d        = DETECT;
            end else if (psola_done_in) begin
               state_d = PUBLISH;
            end else if (boundary) begin
               abort_d        = 1'b1;
               count_d        = count_sat;
               detect_start_d = 1'b1;
               state_d        = DETECT;
            end
         end
         PUBLISH: begin
            out_bank_d = read_bank_out;
            bypass_d   = bypass_flag_q;
            if (boundary) begin
               detect_start_d = 1'b1;
               state_d        = DETECT;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         state_q           <= IDLE;
         bypass_flag_q     <= 1'b0;
         detect_start_out  <= 1'b0;
         psola_start_out   <= 1'b0;
         abort_out         <= 1'b0;
         psola_tau_out     <= '0;
         out_bank_out      <= 1'b0;
         bypass_out        <= 1'b0;
         overrun_count_out <= 8'd0;
      end else begin
         state_q           <= state_d;
         bypass_flag_q     <= bypass_flag_d;
         detect_start_out  <= detect_start_d;
         psola_start_out   <= psola_start_d;
         abort_out         <= abort_d;
         psola_tau_out     <= tau_d;
         out_bank_out      <= out_bank_d;
         bypass_out        <= bypass_d;
         overrun_count_out <= count_d;
      end
   end

endmodule

// File: tb/tb_psola_window_scheduler.sv
// Directed bench: a full-size scheduler for the window flow, a 16-sample one for overrun saturation.
module tb_psola_window_scheduler;

   logic        clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   // Main instance, default geometry.
   logic        rst_in, sample_valid_in, tau_valid_in, psola_done_in;
   logic [10:0] tau_in;
   logic [10:0] write_addr_out;
   logic        write_bank_out, read_bank_out, window_done_out, detect_start_out;
   logic        psola_start_out, abort_out, out_bank_out, bypass_out, busy_out;
   logic [10:0] psola_tau_out;
   logic [7:0]  overrun_count_out;

   // Small instance for overrun saturation.
   logic        rst2, valid2, tau_valid2, done2;
   logic [10:0] tau2;
   logic [3:0]  addr2;
   logic        wbank2, rbank2, wdone2, det2, pstart2, abort2, obank2, byp2, busy2;
   logic [10:0] ptau2;
   logic [7:0]  cnt2;

   int n_tests = 0;
   int n_fail  = 0;
   int det_seen;

   psola_window_scheduler #(.WINDOW_SIZE(2048), .TAU_WIDTH(11), .MIN_TAU(20)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .sample_valid_in(sample_valid_in),
      .write_addr_out(write_addr_out), .write_bank_out(write_bank_out),
      .read_bank_out(read_bank_out), .window_done_out(window_done_out),
      .detect_start_out(detect_start_out), .tau_in(tau_in), .tau_valid_in(tau_valid_in),
      .psola_start_out(psola_start_out), .psola_tau_out(psola_tau_out),
      .psola_done_in(psola_done_in), .abort_out(abort_out), .out_bank_out(out_bank_out),
      .bypass_out(bypass_out), .overrun_count_out(overrun_count_out), .busy_out(busy_out)
   );

   psola_window_scheduler #(.WINDOW_SIZE(16), .TAU_WIDTH(11), .MIN_TAU(20)) dut_small (
      .clk_in(clk_in), .rst_in(rst2), .sample_valid_in(valid2),
      .write_addr_out(addr2), .write_bank_out(wbank2),
      .read_bank_out(rbank2), .window_done_out(wdone2),
      .detect_start_out(det2), .tau_in(tau2), .tau_valid_in(tau_valid2),
      .psola_start_out(pstart2), .psola_tau_out(ptau2),
      .psola_done_in(done2), .abort_out(abort2), .out_bank_out(obank2),
      .bypass_out(byp2), .overrun_count_out(cnt2), .busy_out(busy2)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   // Streams n samples; counts detect_start pulses seen along the way.
   task automatic send_samples(input int n);
      det_seen = 0;
      sample_valid_in = 1'b1;
      for (int i = 0; i < n; i++) begin
         tick();
         if (detect_start_out) det_seen++;
      end
      sample_valid_in = 1'b0;
   endtask

   task automatic send_tau(input logic [10:0] t);
      tau_in = t;
      tau_valid_in = 1'b1;
      tick();
      tau_valid_in = 1'b0;
   endtask

   initial begin
      int aborts, dones;
      rst_in = 1'b0; sample_valid_in = 1'b0; tau_valid_in = 1'b0; psola_done_in = 1'b0; tau_in = '0;
      rst2 = 1'b0; valid2 = 1'b0; tau_valid2 = 1'b0; done2 = 1'b0; tau2 = '0;
      #1;
      repeat (4) tick();

      chk("rst_addr", write_addr_out, 0);
      chk("rst_wbank", write_bank_out, 0);
      chk("rst_rbank", read_bank_out, 1);
      chk("rst_pulses", {window_done_out, detect_start_out, psola_start_out, abort_out}, 0);
      chk("rst_pub", {out_bank_out, bypass_out, busy_out}, 0);
      chk("rst_cnt", overrun_count_out, 0);
      chk("rst_tau", psola_tau_out, 0);
      rst_in = 1'b1;
      rst2 = 1'b1;

      // First window fills bank 0.
      send_samples(2048);
      chk("w1_det_pulses", det_seen, 1);
      chk("w1_det", detect_start_out, 1);
      chk("w1_done", window_done_out, 1);
      chk("w1_wbank", write_bank_out, 1);
      chk("w1_addr", write_addr_out, 0);
      tick();
      chk("w1_det_1cyc", detect_start_out, 0);
      chk("w1_busy", busy_out, 1);

      // Voiced: tau 200, done 30 cycles later.
      send_tau(11'd200);
      chk("v_pstart", psola_start_out, 1);
      chk("v_tau", psola_tau_out, 200);
      tick();
      chk("v_pstart_1cyc", psola_start_out, 0);
      repeat (28) tick();
      psola_done_in = 1'b1;
      tick();
      psola_done_in = 1'b0;
      chk("v_publish_busy", busy_out, 1);
      tick();
      chk("v_obank", out_bank_out, 0);
      chk("v_bypass", bypass_out, 0);
      chk("v_idle", busy_out, 0);

      // Bypass: tau below MIN_TAU on window bank 1.
      send_samples(2048);
      chk("b_wbank", write_bank_out, 0);
      send_tau(11'd5);
      chk("b_no_pstart", psola_start_out, 0);
      tick();
      chk("b_obank", out_bank_out, 1);
      chk("b_bypass", bypass_out, 1);
      chk("b_tau_held", psola_tau_out, 200);

      // Bypass: tau above WINDOW_SIZE/2 on window bank 0.
      send_samples(2048);
      send_tau(11'd1025);
      chk("hi_no_pstart", psola_start_out, 0);
      tick();
      chk("hi_obank", out_bank_out, 0);
      chk("hi_bypass", bypass_out, 1);

      // tau == MIN_TAU is voiced; then withhold done across the boundary.
      send_samples(2048);
      send_tau(11'd20);
      chk("min_pstart", psola_start_out, 1);
      chk("min_tau", psola_tau_out, 20);
      send_samples(2048);
      chk("ov_abort", abort_out, 1);
      chk("ov_det", detect_start_out, 1);
      chk("ov_cnt", overrun_count_out, 1);
      chk("ov_obank", out_bank_out, 0);
      chk("ov_bypass", bypass_out, 1);
      tick();
      chk("ov_abort_1cyc", abort_out, 0);

      // tau on the boundary cycle: overrun wins, tau discarded.
      send_samples(2047);
      sample_valid_in = 1'b1; tau_in = 11'd300; tau_valid_in = 1'b1;
      tick();
      sample_valid_in = 1'b0; tau_valid_in = 1'b0;
      chk("st_abort", abort_out, 1);
      chk("st_no_pstart", psola_start_out, 0);
      chk("st_cnt", overrun_count_out, 2);
      chk("st_tau_kept", psola_tau_out, 20);
      chk("st_det", detect_start_out, 1);

      // done on the boundary cycle: publish the old read bank, no overrun.
      send_tau(11'd300);
      chk("sd_pstart", psola_start_out, 1);
      send_samples(2047);
      sample_valid_in = 1'b1; psola_done_in = 1'b1;
      tick();
      sample_valid_in = 1'b0; psola_done_in = 1'b0;
      chk("sd_no_abort", abort_out, 0);
      chk("sd_cnt", overrun_count_out, 2);
      chk("sd_obank", out_bank_out, 1);
      chk("sd_bypass", bypass_out, 0);
      chk("sd_det", detect_start_out, 1);
      chk("sd_wbank", write_bank_out, 1);

      // Reset in SYNTH drops the job silently.
      send_tau(11'd100);
      chk("mr_pstart", psola_start_out, 1);
      tick();
      rst_in = 1'b0;
      tick();
      rst_in = 1'b1;
      chk("mr_abort", abort_out, 0);
      chk("mr_pub", {out_bank_out, bypass_out, busy_out}, 0);
      chk("mr_cnt", overrun_count_out, 0);
      chk("mr_tau", psola_tau_out, 0);
      chk("mr_bank", {write_bank_out, detect_start_out, psola_start_out}, 0);
      psola_done_in = 1'b1;
      tick();
      psola_done_in = 1'b0;
      chk("mr_done_ign", busy_out, 0);
      tick();
      chk("mr_done_obank", out_bank_out, 0);
      send_tau(11'd100);
      chk("idle_tau_ign", {psola_start_out, busy_out}, 0);

      // Saturation: 300 overruns on the 16-sample instance.
      aborts = 0;
      dones  = 0;
      valid2 = 1'b1;
      for (int i = 0; i < 16 * 301; i++) begin
         tick();
         if (abort2) aborts++;
         if (wdone2) dones++;
         if (i == 31) chk("sat_first", cnt2, 1);
      end
      valid2 = 1'b0;
      chk("sat_aborts", aborts, 300);
      chk("sat_windows", dones, 301);
      chk("sat_cnt", cnt2, 255);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
